// File: rtl/dm_access_ctrl.sv
// Shares the byte-wide single-port data RAM between the CPU load/store port and the
// debug read port: round-robin grant, one RAM byte per cycle, load reassembly and extension.
module dm_access_ctrl #(
    parameter int ADDR_W = 8,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              wr_lock,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [31:0]       cpu_wdata,
    input  logic [2:0]        cpu_type,
    output logic              cpu_gnt,
    output logic              cpu_done,
    output logic [31:0]       cpu_rdata,
    input  logic              dbg_req,
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic              dbg_gnt,
    output logic              dbg_done,
    output logic [31:0]       dbg_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata,
    output logic              busy
);

    typedef enum logic [1:0] {S_IDLE, S_XFER, S_LAST, S_DONE} state_t;

    localparam logic [1:0] LAT_K = 2'(RD_LAT);

    state_t            state_reg;
    logic              port_reg;      // 0 = CPU owns the access, 1 = debug
    logic              rr_reg;        // 1 = debug wins the next tie
    logic              armed_reg;
    logic              we_reg;
    logic [2:0]        type_reg;
    logic [ADDR_W-1:0] base_reg;
    logic [3:0][7:0]   wdata_reg;
    logic [1:0]        k_reg;
    logic [1:0]        last_k_reg;
    logic [3:0][7:0]   lane_reg;
    logic [3:0][7:0]   lane_next;
    logic [31:0]       cpu_rdata_reg;
    logic [31:0]       dbg_rdata_reg;

    logic              idle_ok;
    logic              pick_dbg;
    logic              grant;
    logic              xfer;
    logic              cap_en;
    logic [1:0]        cap_idx;
    logic [31:0]       word_next;
    logic [31:0]       ext_word;

    function automatic logic [1:0] last_index(input logic [2:0] t);
        case (t)
            3'b001, 3'b010: last_index = 2'd1;
            3'b011, 3'b100: last_index = 2'd0;
            default:        last_index = 2'd3;
        endcase
    endfunction

    // armed_reg holds off grants for the first cycle after reset so every output reads 0 in reset
    assign idle_ok  = (state_reg == S_IDLE) && armed_reg;
    assign pick_dbg = dbg_req && (!cpu_req || rr_reg);
    assign cpu_gnt  = idle_ok && cpu_req && !pick_dbg;
    assign dbg_gnt  = idle_ok && pick_dbg;
    assign grant    = cpu_gnt || dbg_gnt;

    assign xfer      = (state_reg == S_XFER);
    assign mem_en    = xfer;
    assign mem_we    = xfer && we_reg && !wr_lock;
    assign mem_addr  = xfer ? base_reg + ADDR_W'(k_reg) : '0;
    assign mem_wdata = (xfer && we_reg) ? wdata_reg[k_reg] : '0;

    assign busy      = (state_reg != S_IDLE);
    assign cpu_done  = (state_reg == S_DONE) && !port_reg;
    assign dbg_done  = (state_reg == S_DONE) && port_reg;
    assign cpu_rdata = cpu_rdata_reg;
    assign dbg_rdata = dbg_rdata_reg;

    // Read data lags the strobe by RD_LAT, so the byte arriving now belongs to lane k-RD_LAT
    assign cap_en  = (xfer && !we_reg && (k_reg >= LAT_K)) || (state_reg == S_LAST);
    assign cap_idx = (state_reg == S_LAST) ? last_k_reg : k_reg - LAT_K;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign lane_next[gi] = (cap_en && (cap_idx == 2'(gi))) ? mem_rdata : lane_reg[gi];
        end
    endgenerate

    assign word_next = lane_next;

    always_comb begin
        ext_word = word_next;
        case (type_reg)
            3'b001:  ext_word = {{16{word_next[15]}}, word_next[15:0]};
            3'b011:  ext_word = {{24{word_next[7]}}, word_next[7:0]};
            default: ext_word = word_next;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_reg     <= S_IDLE;
            port_reg      <= 1'b0;
            rr_reg        <= 1'b0;
            armed_reg     <= 1'b0;
            we_reg        <= 1'b0;
            type_reg      <= '0;
            base_reg      <= '0;
            wdata_reg     <= '0;
            k_reg         <= '0;
            last_k_reg    <= '0;
            lane_reg      <= '0;
            cpu_rdata_reg <= '0;
            dbg_rdata_reg <= '0;
        end else begin
            armed_reg <= 1'b1;
            lane_reg  <= grant ? '0 : lane_next;
            case (state_reg)
                S_IDLE: begin
                    if (grant) begin
                        port_reg   <= dbg_gnt;
                        base_reg   <= dbg_gnt ? dbg_addr : cpu_addr;
                        we_reg     <= cpu_gnt && cpu_we;
                        type_reg   <= dbg_gnt ? 3'b000 : cpu_type;
                        wdata_reg  <= dbg_gnt ? '0 : cpu_wdata;
                        k_reg      <= '0;
                        last_k_reg <= dbg_gnt ? 2'd3 : last_index(cpu_type);
                        if (cpu_req && dbg_req)
                            rr_reg <= cpu_gnt;
                        state_reg  <= S_XFER;
                    end
                end
                S_XFER: begin
                    if (k_reg == last_k_reg)
                        state_reg <= we_reg ? S_DONE : S_LAST;
                    else
                        k_reg <= k_reg + 2'd1;
                end
                S_LAST: begin
                    if (port_reg)
                        dbg_rdata_reg <= word_next;
                    else
                        cpu_rdata_reg <= ext_word;
                    state_reg <= S_DONE;
                end
                S_DONE: state_reg <= S_IDLE;
                default: state_reg <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dm_access_ctrl.sv
// Directed bench for dm_access_ctrl: stimulus pushes expected grants, completions and RAM
// writes into queues; a negedge monitor pops and compares them as the DUT produces them.
module tb_dm_access_ctrl;

    typedef struct packed {
        logic        port;
        logic        is_load;
        logic [31:0] data;
    } done_t;

    logic        clk;
    logic        rstn;
    logic        wr_lock;
    logic        cpu_req;
    logic        cpu_we;
    logic [7:0]  cpu_addr;
    logic [31:0] cpu_wdata;
    logic [2:0]  cpu_type;
    logic        cpu_gnt;
    logic        cpu_done;
    logic [31:0] cpu_rdata;
    logic        dbg_req;
    logic [7:0]  dbg_addr;
    logic        dbg_gnt;
    logic        dbg_done;
    logic [31:0] dbg_rdata;
    logic        mem_en;
    logic        mem_we;
    logic [7:0]  mem_addr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;
    logic        busy;

    logic [7:0]  ram [256];
    logic        exp_gnt_q [$];
    done_t       exp_done_q [$];
    logic [15:0] exp_wr_q [$];

    int checks   = 0;
    int failures = 0;

    dm_access_ctrl #(.ADDR_W(8), .RD_LAT(1)) dut (
        .clk(clk), .rstn(rstn), .wr_lock(wr_lock),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_type(cpu_type), .cpu_gnt(cpu_gnt), .cpu_done(cpu_done), .cpu_rdata(cpu_rdata),
        .dbg_req(dbg_req), .dbg_addr(dbg_addr), .dbg_gnt(dbg_gnt), .dbg_done(dbg_done),
        .dbg_rdata(dbg_rdata), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Byte-wide RAM with one-cycle registered read
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we)
                ram[mem_addr] <= mem_wdata;
            else
                mem_rdata <= ram[mem_addr];
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    task automatic flag(input string name, input logic [31:0] act);
        checks++;
        failures++;
        $display("FAIL %s: got %08h expected nothing", name, act);
    endtask

    always @(negedge clk) begin
        if (rstn) begin
            if (cpu_gnt || dbg_gnt) begin
                check("gnt_onehot", 32'(cpu_gnt & dbg_gnt), 32'h0);
                if (exp_gnt_q.size() == 0)
                    flag("unexpected_gnt", 32'({cpu_gnt, dbg_gnt}));
                else
                    check("gnt_port", 32'(dbg_gnt), 32'(exp_gnt_q.pop_front()));
            end
            if (cpu_done || dbg_done) begin
                if (exp_done_q.size() == 0) begin
                    flag("unexpected_done", 32'({cpu_done, dbg_done}));
                end else begin
                    done_t e;
                    e = exp_done_q.pop_front();
                    check("done_port", 32'({cpu_done, dbg_done}), e.port ? 32'h1 : 32'h2);
                    if (e.is_load)
                        check(e.port ? "dbg_rdata" : "cpu_rdata",
                              e.port ? dbg_rdata : cpu_rdata, e.data);
                end
            end
            if (mem_en && mem_we) begin
                if (exp_wr_q.size() == 0)
                    flag("unexpected_write", 32'({mem_addr, mem_wdata}));
                else
                    check("ram_write", 32'({mem_addr, mem_wdata}), 32'(exp_wr_q.pop_front()));
            end
        end
    end

    task automatic push_wr(input logic [7:0] a, input logic [7:0] d);
        exp_wr_q.push_back({a, d});
    endtask

    task automatic do_op(input logic port, input logic we, input logic [2:0] typ,
                         input logic [7:0] addr, input logic [31:0] wd,
                         input logic [31:0] exp, input int exp_lat);
        logic got;
        int   lat;
        exp_gnt_q.push_back(port);
        exp_done_q.push_back('{port: port, is_load: !we, data: exp});
        @(posedge clk);
        #1;
        if (port) begin
            dbg_req  = 1'b1;
            dbg_addr = addr;
        end else begin
            cpu_req   = 1'b1;
            cpu_we    = we;
            cpu_type  = typ;
            cpu_addr  = addr;
            cpu_wdata = wd;
        end
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            got = port ? dbg_gnt : cpu_gnt;
        end
        check("gnt_seen", 32'(got), 32'h1);
        @(posedge clk);
        #1;
        cpu_req = 1'b0;
        dbg_req = 1'b0;
        lat = 0;
        for (int i = 1; i <= 30; i++) begin
            @(negedge clk);
            if (port ? dbg_done : cpu_done) begin
                lat = i;
                break;
            end
        end
        check("latency", 32'(lat), 32'(exp_lat));
        $display("op port=%0d we=%0d type=%0d addr=%02h wdata=%08h lat=%0d", port, we, typ,
                 addr, wd, lat);
    endtask

    initial begin
        logic got;
        int   g;
        for (int i = 0; i < 256; i++) ram[i] = 8'h00;
        ram[8'h40] = 8'h11; ram[8'h41] = 8'h22; ram[8'h42] = 8'h33; ram[8'h43] = 8'h44;
        ram[8'h20] = 8'h77;
        mem_rdata = 8'h00;
        rstn      = 1'b0;
        wr_lock   = 1'b0;
        // Both requesters load word 0x40 continuously from reset
        cpu_req   = 1'b1;
        cpu_we    = 1'b0;
        cpu_type  = 3'b000;
        cpu_addr  = 8'h40;
        cpu_wdata = 32'h0;
        dbg_req   = 1'b1;
        dbg_addr  = 8'h40;
        #12;
        check("rst_cpu_gnt", 32'(cpu_gnt), 32'h0);
        check("rst_dbg_gnt", 32'(dbg_gnt), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_mem_en", 32'(mem_en), 32'h0);
        check("rst_cpu_rdata", cpu_rdata, 32'h0);
        check("rst_dbg_rdata", dbg_rdata, 32'h0);
        @(posedge clk);
        #1;
        rstn = 1'b1;

        for (int k = 0; k < 2; k++) begin
            exp_gnt_q.push_back(1'b0);
            exp_gnt_q.push_back(1'b1);
            exp_done_q.push_back('{port: 1'b0, is_load: 1'b1, data: 32'h44332211});
            exp_done_q.push_back('{port: 1'b1, is_load: 1'b1, data: 32'h44332211});
        end
        g = 0;
        for (int i = 0; i < 200 && g < 4; i++) begin
            @(negedge clk);
            if (cpu_gnt || dbg_gnt) g++;
        end
        check("arb_grants", 32'(g), 32'h4);
        @(posedge clk);
        #1;
        cpu_req = 1'b0;
        dbg_req = 1'b0;
        repeat (10) @(posedge clk);
        $display("arb grants=%0d", g);

        push_wr(8'h10, 8'hEF); push_wr(8'h11, 8'hBE); push_wr(8'h12, 8'hAD); push_wr(8'h13, 8'hDE);
        do_op(1'b0, 1'b1, 3'b000, 8'h10, 32'hDEADBEEF, 32'h0, 5);
        do_op(1'b0, 1'b0, 3'b000, 8'h10, 32'h0, 32'hDEADBEEF, 6);
        do_op(1'b0, 1'b0, 3'b011, 8'h10, 32'h0, 32'hFFFFFFEF, 3);
        do_op(1'b0, 1'b0, 3'b100, 8'h10, 32'h0, 32'h000000EF, 3);
        do_op(1'b0, 1'b0, 3'b001, 8'h10, 32'h0, 32'hFFFFBEEF, 4);
        do_op(1'b0, 1'b0, 3'b010, 8'h10, 32'h0, 32'h0000BEEF, 4);
        do_op(1'b0, 1'b0, 3'b011, 8'h12, 32'h0, 32'hFFFFFFAD, 3);
        do_op(1'b0, 1'b0, 3'b001, 8'h12, 32'h0, 32'hFFFFDEAD, 4);
        do_op(1'b0, 1'b0, 3'b111, 8'h10, 32'h0, 32'hDEADBEEF, 6);

        wr_lock = 1'b1;
        do_op(1'b0, 1'b1, 3'b011, 8'h20, 32'h00000055, 32'h0, 2);
        do_op(1'b0, 1'b0, 3'b100, 8'h20, 32'h0, 32'h00000077, 3);
        wr_lock = 1'b0;

        push_wr(8'hFE, 8'h04); push_wr(8'hFF, 8'h03); push_wr(8'h00, 8'h02); push_wr(8'h01, 8'h01);
        do_op(1'b0, 1'b1, 3'b000, 8'hFE, 32'h01020304, 32'h0, 5);
        do_op(1'b0, 1'b0, 3'b000, 8'hFE, 32'h0, 32'h01020304, 6);
        push_wr(8'h30, 8'h34); push_wr(8'h31, 8'h12);
        do_op(1'b0, 1'b1, 3'b010, 8'h30, 32'hAAAA1234, 32'h0, 3);
        do_op(1'b0, 1'b0, 3'b000, 8'h30, 32'h0, 32'h00001234, 6);
        do_op(1'b1, 1'b0, 3'b000, 8'h10, 32'h0, 32'hDEADBEEF, 6);

        // Word load at 0x10 abandoned by reset in its third RAM cycle
        exp_gnt_q.push_back(1'b0);
        @(posedge clk);
        #1;
        cpu_req  = 1'b1;
        cpu_we   = 1'b0;
        cpu_type = 3'b000;
        cpu_addr = 8'h10;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            got = cpu_gnt;
        end
        check("rstop_gnt", 32'(got), 32'h1);
        @(posedge clk);
        #1;
        cpu_req = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2;
        check("rstop_mem_en", 32'(mem_en), 32'h1);
        check("rstop_addr", 32'(mem_addr), 32'h12);
        rstn = 1'b0;
        #1;
        check("rstop_out_mem", 32'({mem_en, mem_we, busy, cpu_done, dbg_done}), 32'h0);
        check("rstop_out_addr", 32'(mem_addr), 32'h0);
        check("rstop_cpu_rdata", cpu_rdata, 32'h0);
        check("rstop_dbg_rdata", dbg_rdata, 32'h0);
        repeat (3) @(posedge clk);
        #1;
        rstn = 1'b1;
        repeat (10) @(posedge clk);
        $display("reset abandon done");
        do_op(1'b1, 1'b0, 3'b000, 8'h40, 32'h0, 32'h44332211, 6);
        do_op(1'b0, 1'b0, 3'b000, 8'h10, 32'h0, 32'hDEADBEEF, 6);

        repeat (5) @(posedge clk);
        check("gnt_q_empty", 32'(exp_gnt_q.size()), 32'h0);
        check("done_q_empty", 32'(exp_done_q.size()), 32'h0);
        check("wr_q_empty", 32'(exp_wr_q.size()), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
